fft_stage_sequencer: RTL and testbench
======================================

# fft_stage_sequencer

Sequences one complete radix-2 FFT pass by driving the per-stage address generator through all FFT_N butterfly stages. For each stage it asserts `run`, waits for the generator's `agDone`, then drains the butterfly/memory write-back pipeline for a fixed latency before advancing. It also flips the ping-pong memory bank between stages and reports completion and watchdog errors to the host-side control logic.

## Interface
- FFT_N, 10, log2 of transform length; each stage covers 2^(FFT_N-1) butterfly addresses
- STAGE_COUNT_BW, 4, width of `stageCount`; must satisfy 2^STAGE_COUNT_BW > FFT_N-1
- PIPE_LAT, 3, drain cycles after each stage; legal minimum is 2
- WDOG_MARGIN, 4, extra cycles allowed past 2^(FFT_N-1) before the watchdog fires
- clk  in  1  single clock; all state updates on its rising edge
- reset  in  1  synchronous, active-low (0 = reset)
- start  in  1  one-cycle request to begin a transform; honoured only in IDLE
- agDone  in  1  done flag from the address generator
- run  out  1  run enable to the address generator (registered)
- stageCount  out  STAGE_COUNT_BW  current stage index, 0..FFT_N-1 (registered)
- bankSel  out  1  ping-pong bank select; toggles at every stage end
- busy  out  1  high in RUN and DRAIN
- done  out  1  one-cycle pulse on transform completion
- error  out  1  sticky watchdog error; cleared by the next accepted `start`

## Operation
- States: IDLE, RUN, DRAIN, FIN, using a registered state machine.
- IDLE: `start`=1 moves to RUN. On entry to RUN, `stageCount`=0, `bankSel`=0, `error`=0, and the watchdog is cleared.
- RUN: `run`=1. When `agDone`=1 is sampled, move to DRAIN, load the drain counter with PIPE_LAT-1, and drive `run`=0 from the next cycle.
- DRAIN: `run`=0 and the counter decrements. When the counter reaches 0:
  - if `stageCount`==FFT_N-1, go to FIN;
  - otherwise increment `stageCount`, toggle `bankSel`, and return to RUN.
- FIN: `done`=1 for one cycle, `busy`=0, then go to IDLE. `stageCount` and `bankSel` hold their last values until the next start.
- Watchdog: counts cycles spent in RUN. Reaching 2^(FFT_N-1)+WDOG_MARGIN without `agDone` sets `error`=1 and forces IDLE with no `done` pulse.
- `start` in any state other than IDLE is ignored; there is no queueing.
- `agDone`=1 sampled in DRAIN or IDLE is ignored. PIPE_LAT≥2 guarantees the generator's registered done flag has cleared before `run` is re-asserted.
- Width rule: the drain counter is $clog2(PIPE_LAT) bits and the watchdog counter is FFT_N+1 bits. Neither may wrap silently; both saturate.

## Timing
- Reset (reset=0 sampled): next cycle, state=IDLE and `run`, `stageCount`, `bankSel`, `busy`, `done`, `error` are all 0. This applies mid-transform as well; no `done` is produced.
- `start` sampled at cycle t: `busy`=`run`=1 from t+1.
- Per stage, `run` stays high for 2^(FFT_N-1)+1 cycles (the generator reports done one cycle after its counter fills), then stays low for PIPE_LAT cycles.
- Stage period: 2^(FFT_N-1)+1+PIPE_LAT cycles. Total `busy` time: FFT_N × period. The `done` pulse occurs in the first cycle after `busy` falls.
- `bankSel` and `stageCount` change together on the last DRAIN cycle edge, so they are stable throughout each RUN.

## Configuration
- FFT_SEQ_ABORT_EN defined: adds input port `abort` (1 bit). `abort`=1 in RUN or DRAIN returns to IDLE next cycle with `run`=0 and `busy`=0, no `done` pulse, and `error` unchanged. `abort` has priority over `agDone` and drain completion in the same cycle.
- FFT_SEQ_ABORT_EN undefined: the `abort` port and all associated logic are absent.

## Structure
- Shared package `fft_pkg`: state enum `fft_seq_state_t` (IDLE/RUN/DRAIN/FIN) and a stage-length constant function of FFT_N. The same package serves the address generator and the butterfly unit.
- One sub-module, `fft_seq_watchdog`: a saturating cycle counter with clear, enable, and limit-compare output.

## Test plan
- FFT_N=4, PIPE_LAT=3, generator model attached; pulse `start` -> `run` high 9 cycles then low 3, four times; `stageCount` 0,1,2,3; `bankSel` 0,1,0,1; `busy` high 48 cycles; `done` one pulse in cycle 49 after `start`.
- `start` re-pulsed at stage 2 -> ignored; timing identical to the first scenario.
- `agDone` tied 0 -> `error`=1 after 8+4=12 RUN cycles; IDLE follows with no `done`. A following `start` clears `error`.
- reset=0 asserted mid-DRAIN of stage 1 -> all outputs 0 next cycle. A subsequent `start` runs a full clean transform.
- Spurious `agDone` pulse during DRAIN -> no state change; stage timing unaffected.
- FFT_SEQ_ABORT_EN: `abort` asserted in the same cycle as `agDone` at stage 0 -> IDLE next cycle, `run`=0, `stageCount`=0, no `done`.

Source files
------------

// File: rtl/fft_pkg.sv
// Shared FFT definitions: sequencer state encoding and stage-length helper,
// used by the stage sequencer, address generator and butterfly unit.
package fft_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        RUN   = 2'd1,
        DRAIN = 2'd2,
        FIN   = 2'd3
    } fft_seq_state_t;

    // Butterfly addresses visited by one radix-2 stage of a 2^fftN transform.
    function automatic int stageLen(input int fftN);
        return 1 << (fftN - 1);
    endfunction

endpackage

// File: rtl/fft_seq_watchdog.sv
// Saturating cycle counter with clear/enable; flags the cycle in which the
// enabled count reaches LIMIT cycles.
module fft_seq_watchdog #(
    parameter int WIDTH = 11,
    parameter int LIMIT = 516
) (
    input  logic clk,
    input  logic reset,
    input  logic clear,
    input  logic enable,
    output logic expired
);

    localparam logic [WIDTH-1:0] LAST = WIDTH'(LIMIT - 1);
    localparam logic [WIDTH-1:0] MAXV = '1;

    logic [WIDTH-1:0] count;

    always_ff @(posedge clk) begin
        if (!reset || clear) begin
            count <= '0;
        end else if (enable && count != MAXV) begin
            count <= count + 1'b1;
        end
    end

    // count holds the cycles already spent, so this is the LIMIT-th cycle.
    assign expired = enable && (count >= LAST);

endmodule

// File: rtl/fft_stage_sequencer.sv
// Drives the address generator through all FFT_N radix-2 stages with drain
// gaps and ping-pong bank flips. Optional abort input: FFT_SEQ_ABORT_EN.
module fft_stage_sequencer
    import fft_pkg::*;
#(
    parameter int FFT_N          = 10,
    parameter int STAGE_COUNT_BW = 4,
    parameter int PIPE_LAT       = 3,
    parameter int WDOG_MARGIN    = 4
) (
    input  logic                      clk,
    input  logic                      reset,
    input  logic                      start,
`ifdef FFT_SEQ_ABORT_EN
    input  logic                      abort,
`endif
    input  logic                      agDone,
    output logic                      run,
    output logic [STAGE_COUNT_BW-1:0] stageCount,
    output logic                      bankSel,
    output logic                      busy,
    output logic                      done,
    output logic                      error,
    output fft_seq_state_t            seqState
);

    localparam int STAGE_LEN  = stageLen(FFT_N);
    localparam int WDOG_LIMIT = STAGE_LEN + WDOG_MARGIN;
    localparam int WDOG_W     = FFT_N + 1;
    localparam int DRAIN_W    = $clog2(PIPE_LAT);

    localparam logic [DRAIN_W-1:0]        DRAIN_LOAD = DRAIN_W'(PIPE_LAT - 1);
    localparam logic [STAGE_COUNT_BW-1:0] LAST_STAGE = STAGE_COUNT_BW'(FFT_N - 1);

    fft_seq_state_t     state;
    logic [DRAIN_W-1:0] drainCnt;
    logic               wdogExpired;

    // Watchdog restarts on every entry to RUN, so it measures one stage only.
    fft_seq_watchdog #(
        .WIDTH (WDOG_W),
        .LIMIT (WDOG_LIMIT)
    ) uWatchdog (
        .clk     (clk),
        .reset   (reset),
        .clear   (state != RUN),
        .enable  (state == RUN),
        .expired (wdogExpired)
    );

    always_ff @(posedge clk) begin
        if (!reset) begin
            state      <= IDLE;
            run        <= 1'b0;
            stageCount <= '0;
            bankSel    <= 1'b0;
            busy       <= 1'b0;
            done       <= 1'b0;
            error      <= 1'b0;
            drainCnt   <= '0;
        end else begin
            done <= 1'b0;
            case (state)
                IDLE: begin
                    if (start) begin
                        state      <= RUN;
                        run        <= 1'b1;
                        busy       <= 1'b1;
                        stageCount <= '0;
                        bankSel    <= 1'b0;
                        error      <= 1'b0;
                    end
                end
                RUN: begin
`ifdef FFT_SEQ_ABORT_EN
                    if (abort) begin
                        state <= IDLE;
                        run   <= 1'b0;
                        busy  <= 1'b0;
                    end else
`endif
                    if (agDone) begin
                        state    <= DRAIN;
                        run      <= 1'b0;
                        drainCnt <= DRAIN_LOAD;
                    end else if (wdogExpired) begin
                        state <= IDLE;
                        run   <= 1'b0;
                        busy  <= 1'b0;
                        error <= 1'b1;
                    end
                end
                DRAIN: begin
`ifdef FFT_SEQ_ABORT_EN
                    if (abort) begin
                        state <= IDLE;
                        run   <= 1'b0;
                        busy  <= 1'b0;
                    end else
`endif
                    if (drainCnt == '0) begin
                        if (stageCount == LAST_STAGE) begin
                            state <= FIN;
                            busy  <= 1'b0;
                            done  <= 1'b1;
                        end else begin
                            state      <= RUN;
                            run        <= 1'b1;
                            stageCount <= stageCount + 1'b1;
                            bankSel    <= ~bankSel;
                        end
                    end else begin
                        drainCnt <= drainCnt - 1'b1;
                    end
                end
                FIN: begin
                    state <= IDLE;
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

    assign seqState = state;

endmodule

// File: tb/tb_fft_stage_sequencer.sv
// Scoreboard bench for fft_stage_sequencer at FFT_N=4, PIPE_LAT=3 with a
// behavioural address-generator model; observed output segments are events.
module tb_fft_stage_sequencer;
    import fft_pkg::*;

    localparam int HALF      = 8;   // 2^(4-1) addresses per stage
    localparam int RUN_LEN   = 9;   // 8 addresses + 1 registered done
    localparam int DRAIN_LEN = 3;
    localparam int BUSY_LEN  = 48;  // 4 stages x 12 cycles
    localparam int WDOG_LEN  = 12;  // 8 + margin 4

    logic       clk = 1'b0;
    logic       reset = 1'b0;
    logic       start = 1'b0;
    logic       agDone;
    logic       run;
    logic [3:0] stageCount;
    logic       bankSel;
    logic       busy;
    logic       done;
    logic       error;
    fft_seq_state_t seqState;
`ifdef FFT_SEQ_ABORT_EN
    logic       abort = 1'b0;
`endif

    logic       genEn = 1'b1;
    logic       forceDone = 1'b0;
    logic [3:0] genCnt;
    logic       genDone;

    int errors = 0;
    int checks = 0;
    logic [31:0] exp_q[$];

    // ---------------- clock / reset ----------------
    always #5 clk = ~clk;

    initial begin
        #1_000_000;
        $display("FAIL global_timeout: simulation still running at %0t", $time);
        $fatal(1, "global timeout");
    end

    fft_stage_sequencer #(
        .FFT_N          (4),
        .STAGE_COUNT_BW (4),
        .PIPE_LAT       (3),
        .WDOG_MARGIN    (4)
    ) dut (
        .clk        (clk),
        .reset      (reset),
        .start      (start),
`ifdef FFT_SEQ_ABORT_EN
        .abort      (abort),
`endif
        .agDone     (agDone),
        .run        (run),
        .stageCount (stageCount),
        .bankSel    (bankSel),
        .busy       (busy),
        .done       (done),
        .error      (error),
        .seqState   (seqState)
    );

    // Address generator model: counts HALF run cycles, then a one-cycle done.
    always @(posedge clk) begin
        if (!reset || !genEn) begin
            genCnt  <= '0;
            genDone <= 1'b0;
        end else if (genDone) begin
            genDone <= 1'b0;
        end else if (run) begin
            if (genCnt == 4'(HALF - 1)) begin
                genCnt  <= '0;
                genDone <= 1'b1;
            end else begin
                genCnt <= genCnt + 1'b1;
            end
        end
    end
    assign agDone = genDone | forceDone;

    // ---------------- event encoding ----------------
    function automatic logic [31:0] evRun(input int stable, input int stg, input int bank, input int len);
        return {4'd1, 6'd0, 1'(stable), 4'(stg), 1'(bank), 16'(len)};
    endfunction
    function automatic logic [31:0] evLow(input int len);
        return {4'd2, 12'd0, 16'(len)};
    endfunction
    function automatic logic [31:0] evBusy(input int len);
        return {4'd3, 12'd0, 16'(len)};
    endfunction
    function automatic logic [31:0] evDone(input int off, input int len);
        return {4'd4, 4'd0, 16'(off), 8'(len)};
    endfunction
    function automatic logic [31:0] evErrSet(input int off);
        return {4'd5, 12'd0, 16'(off)};
    endfunction
    function automatic logic [31:0] evErrClr(input int off);
        return {4'd6, 12'd0, 16'(off)};
    endfunction

    // ---------------- scoreboard ----------------
    task automatic emit(input string name, input logic [31:0] got);
        logic [31:0] e;
        checks++;
        if (exp_q.size() == 0) begin
            errors++;
            $display("FAIL %s: got event %h, expected no event", name, got);
        end else begin
            e = exp_q.pop_front();
            if (got !== e) begin
                errors++;
                $display("FAIL %s: got event %h, expected %h", name, got, e);
            end
        end
    endtask

    task automatic checkEq(input string name, input int got, input int exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0d, expected %0d", name, got, exp);
        end
    endtask

    // Monitor: turns output waveforms into segment events, sampled mid-cycle.
    int cyc = 0;
    int busyRise = 0, runLen = 0, lowLen = 0, busyLen = 0, doneLen = 0, doneOff = 0;
    int segStage = 0, segBank = 0, segStable = 1;
    logic pRun = 1'b0, pBusy = 1'b0, pDone = 1'b0, pErr = 1'b0;
    logic cRun, cBusy, cDone, cErr;

    always @(negedge clk) begin
        cyc++;
        cRun  = (run === 1'b1);
        cBusy = (busy === 1'b1);
        cDone = (done === 1'b1);
        cErr  = (error === 1'b1);
        if (cBusy && !pBusy) busyRise = cyc;
        if (cRun) begin
            if (!pRun) begin
                runLen = 0; segStage = int'(stageCount); segBank = int'(bankSel); segStable = 1;
            end
            if (int'(stageCount) != segStage || int'(bankSel) != segBank) segStable = 0;
            runLen++;
        end else if (pRun) begin
            emit("run_segment", evRun(segStable, segStage, segBank, runLen));
        end
        if (cBusy && !cRun) begin
            lowLen++;
        end else if (pBusy && !pRun) begin
            emit("drain_segment", evLow(lowLen));
            lowLen = 0;
        end
        if (cBusy) begin
            busyLen = pBusy ? busyLen + 1 : 1;
        end else if (pBusy) begin
            emit("busy_length", evBusy(busyLen));
        end
        if (cDone) begin
            if (!pDone) begin doneOff = cyc - busyRise; doneLen = 0; end
            doneLen++;
        end else if (pDone) begin
            emit("done_pulse", evDone(doneOff, doneLen));
        end
        if (cErr && !pErr) emit("error_set", evErrSet(cyc - busyRise));
        if (!cErr && pErr) emit("error_clear", evErrClr(cyc - busyRise));
        pRun = cRun; pBusy = cBusy; pDone = cDone; pErr = cErr;
    end

    // ---------------- driver tasks ----------------
    task automatic step(input int n);
        repeat (n) begin @(posedge clk); #1; end
    endtask

    task automatic pulseStart();
        start = 1'b1;
        step(1);
        start = 1'b0;
    endtask

    task automatic expectTransform();
        int bankExp[4];
        bankExp = '{0, 1, 0, 1};
        for (int s = 0; s < 4; s++) begin
            exp_q.push_back(evRun(1, s, bankExp[s], RUN_LEN));
            exp_q.push_back(evLow(DRAIN_LEN));
        end
        exp_q.push_back(evBusy(BUSY_LEN));
        exp_q.push_back(evDone(BUSY_LEN, 1));
    endtask

    task automatic waitBusyLow(input string name, input int bound);
        int n = 0;
        while (busy === 1'b1 && n < bound) begin step(1); n++; end
        checks++;
        if (busy === 1'b1) begin
            errors++;
            $display("FAIL %s: busy still 1 after %0d cycles, expected 0", name, bound);
        end
    endtask

    task automatic waitFirstDrain(input string name, input int stg);
        int n = 0;
        while (!(busy === 1'b1 && run === 1'b0 && int'(stageCount) == stg) && n < 80) begin
            step(1); n++;
        end
        checks++;
        if (n >= 80) begin
            errors++;
            $display("FAIL %s: drain of stage %0d not reached, expected within 80 cycles", name, stg);
        end
    endtask

    task automatic checkAllZero(input string tag);
        checkEq({tag, "_run"}, int'(run), 0);
        checkEq({tag, "_stageCount"}, int'(stageCount), 0);
        checkEq({tag, "_bankSel"}, int'(bankSel), 0);
        checkEq({tag, "_busy"}, int'(busy), 0);
        checkEq({tag, "_done"}, int'(done), 0);
        checkEq({tag, "_error"}, int'(error), 0);
        checkEq({tag, "_state"}, int'(seqState), int'(IDLE));
    endtask

    // ---------------- stimulus ----------------
    initial begin
        step(3);
        checkAllZero("reset");
        reset = 1'b1;
        step(2);

        // Plain transform.
        expectTransform();
        pulseStart();
        waitBusyLow("plain_busy", 100);
        step(3);

        // Start re-pulsed during stage 2 is ignored.
        expectTransform();
        pulseStart();
        waitFirstDrain("repulse_wait", 2);
        pulseStart();
        waitBusyLow("repulse_busy", 100);
        step(3);

        // Generator never answers: watchdog error, no done.
        genEn = 1'b0;
        exp_q.push_back(evRun(1, 0, 0, WDOG_LEN));
        exp_q.push_back(evBusy(WDOG_LEN));
        exp_q.push_back(evErrSet(WDOG_LEN));
        pulseStart();
        waitBusyLow("wdog_busy", 40);
        step(3);
        checkEq("wdog_error_sticky", int'(error), 1);
        checkEq("wdog_idle", int'(seqState), int'(IDLE));
        genEn = 1'b1;
        exp_q.push_back(evErrClr(0));
        expectTransform();
        pulseStart();
        waitBusyLow("after_wdog_busy", 100);
        step(3);

        // Reset during the first drain cycle of stage 1.
        exp_q.push_back(evRun(1, 0, 0, RUN_LEN));
        exp_q.push_back(evLow(DRAIN_LEN));
        exp_q.push_back(evRun(1, 1, 1, RUN_LEN));
        exp_q.push_back(evLow(1));
        exp_q.push_back(evBusy(22));
        pulseStart();
        waitFirstDrain("midreset_wait", 1);
        reset = 1'b0;
        step(1);
        checkAllZero("midreset");
        reset = 1'b1;
        step(3);
        expectTransform();
        pulseStart();
        waitBusyLow("after_reset_busy", 100);
        step(3);

        // Spurious agDone inside a drain window.
        expectTransform();
        pulseStart();
        waitFirstDrain("spurious_wait", 1);
        step(1);
        forceDone = 1'b1;
        step(1);
        forceDone = 1'b0;
        waitBusyLow("spurious_busy", 100);
        step(3);

`ifdef FFT_SEQ_ABORT_EN
        // Abort coincident with agDone at stage 0.
        begin
            int n = 0;
            exp_q.push_back(evRun(1, 0, 0, RUN_LEN));
            exp_q.push_back(evBusy(RUN_LEN));
            pulseStart();
            while (agDone !== 1'b1 && n < 30) begin step(1); n++; end
            checkEq("abort_agdone_seen", int'(agDone === 1'b1), 1);
            abort = 1'b1;
            step(1);
            abort = 1'b0;
            checkEq("abort_run", int'(run), 0);
            checkEq("abort_busy", int'(busy), 0);
            checkEq("abort_stageCount", int'(stageCount), 0);
            checkEq("abort_state", int'(seqState), int'(IDLE));
            step(4);
        end
`endif

        step(5);
        checks++;
        if (exp_q.size() != 0) begin
            errors++;
            $display("FAIL leftover_events: got %0d unmatched expected events, expected 0", exp_q.size());
        end
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
